// File: rtl/packet_mem_to_gmii_tx_if.sv
// Store-side read port: packet availability, head length, read strobe and the byte returned one cycle later.
interface packet_mem_to_gmii_tx_if #(
  parameter int pDATA_WIDTH = 8,
  parameter int pLEN_WIDTH  = 16
);
  logic                   iempty;
  logic [pLEN_WIDTH-1:0]  ilen_pac;
  logic [pDATA_WIDTH-1:0] idata;
  logic                   inext_last;
  logic                   ord_en;

  modport master (output iempty, ilen_pac, idata, inext_last, input ord_en);
  modport slave  (input iempty, ilen_pac, idata, inext_last, output ord_en);
endinterface

// File: rtl/packet_mem_to_gmii_tx.sv
// Drains stored frames as GMII bytes (7x55, D5, data, IFG); first preamble byte 1 cycle after start, no backpressure.
// ien gates only frame start. Defining PACKET_TX_PAD_EN pads short frames with 0x00 up to pMIN_FRAME bytes.
module packet_mem_to_gmii_tx #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pLEN_WIDTH         = 16,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pPREAMBLE_BYTES    = 7,
  parameter int pIFG_BYTES         = 12,
  parameter int pMIN_FRAME         = 60
) (
  input  logic                   iclk,
  input  logic                   i_rst_n,
  input  logic                   ien,
  packet_mem_to_gmii_tx_if.slave store,
  output logic [pDATA_WIDTH-1:0] otx_d,
  output logic                   otx_en,
  output logic                   obusy,
  output logic                   oerr_len,
  output logic                   oerr_sync,
  output logic [15:0]            oframes
);

  localparam logic [pLEN_WIDTH-1:0]  LEN_ONE  = pLEN_WIDTH'(1);
  localparam logic [pLEN_WIDTH-1:0]  MAX_LEN  = pLEN_WIDTH'(pMAX_PACKET_LENGHT);
  localparam logic [pLEN_WIDTH-1:0]  PRE_LAST = pLEN_WIDTH'(pPREAMBLE_BYTES - 1);
  localparam logic [pLEN_WIDTH-1:0]  PRE_RD   = pLEN_WIDTH'(pPREAMBLE_BYTES - 2);
  localparam logic [pLEN_WIDTH-1:0]  IFG_LAST = pLEN_WIDTH'(pIFG_BYTES - 1);
  localparam logic [pDATA_WIDTH-1:0] PRE_BYTE = pDATA_WIDTH'(8'h55);
  localparam logic [pDATA_WIDTH-1:0] SFD_BYTE = pDATA_WIDTH'(8'hD5);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DISCARD, IFG} state_t;

  state_t                state;
  logic [pLEN_WIDTH-1:0] len_q;
  logic [pLEN_WIDTH-1:0] cnt;
  logic [pLEN_WIDTH-1:0] rd_cnt;
  logic                  ord_en_q;
  logic                  data_vld;
  logic [pLEN_WIDTH-1:0] len_last;
  logic [pLEN_WIDTH-1:0] frame_last;
  logic                  reading;
  logic                  rd_more;
  logic                  byte_last;
  logic                  sync_bad;

  assign len_last = len_q - LEN_ONE;

`ifdef PACKET_TX_PAD_EN
  localparam logic [pLEN_WIDTH-1:0] MIN_LEN = pLEN_WIDTH'(pMIN_FRAME);
  assign frame_last = (len_q < MIN_LEN) ? (MIN_LEN - LEN_ONE) : len_last;
`else
  assign frame_last = len_last;
`endif

  // Reads start two cycles before the SFD so byte 0 follows it with no gap.
  assign reading   = ((state == PREAMBLE) && (cnt >= PRE_RD)) || (state == DATA) || (state == DISCARD);
  assign rd_more   = reading && (rd_cnt < len_q);
  assign byte_last = (cnt == len_last);
  assign sync_bad  = data_vld && (store.inext_last != byte_last);

  assign store.ord_en = ord_en_q;
  assign obusy        = (state != IDLE);

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      rd_cnt    <= '0;
      ord_en_q  <= 1'b0;
      data_vld  <= 1'b0;
      otx_d     <= '0;
      otx_en    <= 1'b0;
      oerr_len  <= 1'b0;
      oerr_sync <= 1'b0;
      oframes   <= '0;
    end else begin
      ord_en_q <= rd_more;
      data_vld <= ord_en_q;
      if (rd_more) rd_cnt <= rd_cnt + LEN_ONE;

      case (state)
        IDLE: begin
          otx_en <= 1'b0;
          otx_d  <= '0;
          cnt    <= '0;
          rd_cnt <= '0;
          if (ien && !store.iempty) begin
            len_q <= store.ilen_pac;
            if (store.ilen_pac > MAX_LEN) begin
              state    <= DISCARD;
              oerr_len <= 1'b1;
            end else begin
              state  <= PREAMBLE;
              otx_en <= 1'b1;
              otx_d  <= PRE_BYTE;
            end
          end
        end

        PREAMBLE: begin
          otx_en <= 1'b1;
          if (cnt == PRE_LAST) begin
            otx_d <= SFD_BYTE;
            cnt   <= '0;
            state <= DATA;
          end else begin
            otx_d <= PRE_BYTE;
            cnt   <= cnt + LEN_ONE;
          end
        end

        DATA: begin
          otx_en <= 1'b1;
          if (data_vld) begin
            otx_d <= store.idata;
            if (sync_bad) oerr_sync <= 1'b1;
          end else begin
            otx_d <= '0;
          end
          if (cnt == frame_last) begin
            cnt     <= '0;
            state   <= IFG;
            oframes <= oframes + 16'd1;
          end else begin
            cnt <= cnt + LEN_ONE;
          end
        end

        DISCARD: begin
          otx_en <= 1'b0;
          otx_d  <= '0;
          if (data_vld) begin
            if (sync_bad) oerr_sync <= 1'b1;
            if (byte_last) begin
              cnt   <= '0;
              state <= IFG;
            end else begin
              cnt <= cnt + LEN_ONE;
            end
          end
        end

        IFG: begin
          otx_en <= 1'b0;
          otx_d  <= '0;
          if (cnt == IFG_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + LEN_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_mem_to_gmii_tx.sv
// Bench for packet_mem_to_gmii_tx: a queue-based store model feeds the DUT and a scoreboard checks every transmitted byte.
module tb_packet_mem_to_gmii_tx;
  localparam int MAX_LEN = 1536;

  logic        iclk = 1'b0;
  logic        i_rst_n;
  logic        ien;
  logic [7:0]  otx_d;
  logic        otx_en;
  logic        obusy;
  logic        oerr_len;
  logic        oerr_sync;
  logic [15:0] oframes;

  packet_mem_to_gmii_tx_if #(.pDATA_WIDTH(8), .pLEN_WIDTH(16)) store_bus ();

  packet_mem_to_gmii_tx dut (
    .iclk      (iclk),
    .i_rst_n   (i_rst_n),
    .ien       (ien),
    .store     (store_bus),
    .otx_d     (otx_d),
    .otx_en    (otx_en),
    .obusy     (obusy),
    .oerr_len  (oerr_len),
    .oerr_sync (oerr_sync),
    .oframes   (oframes)
  );

  always #5 iclk = ~iclk;

  int vectors     = 0;
  int miscompares = 0;

  logic [8:0] st_bytes[$];
  int         st_lens[$];
  int         st_cnt = 0;
  bit         pend   = 1'b0;

  logic [7:0] exp_q[$];
  int         exp_frames = 0;

  bit mon_off   = 1'b1;
  int tx_en_cnt = 0;
  int ord_cnt   = 0;
  int low_run   = 0;
  int last_gap  = -1;
  bit prev_en   = 1'b0;

  // Store model: returns the byte the cycle after each read strobe.
  initial begin : store_model
    store_bus.iempty     = 1'b1;
    store_bus.ilen_pac   = '0;
    store_bus.idata      = '0;
    store_bus.inext_last = 1'b0;
    forever begin
      @(posedge iclk); #1;
      if (pend && st_bytes.size() > 0) begin
        {store_bus.inext_last, store_bus.idata} = st_bytes.pop_front();
        st_cnt++;
        if (st_lens.size() > 0 && st_cnt == st_lens[0]) begin
          void'(st_lens.pop_front());
          st_cnt = 0;
        end
      end else begin
        store_bus.idata      = '0;
        store_bus.inext_last = 1'b0;
      end
      pend = store_bus.ord_en;
      store_bus.iempty   = (st_lens.size() == 0);
      store_bus.ilen_pac = (st_lens.size() > 0) ? 16'(st_lens[0]) : 16'd0;
    end
  end

  initial begin : monitor
    logic [7:0] exp_b;
    forever begin
      @(negedge iclk);
      if (!mon_off) begin
        if (store_bus.ord_en) ord_cnt++;
        vectors++;
        if (otx_en) begin
          tx_en_cnt++;
          if (!prev_en) last_gap = low_run;
          low_run = 0;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL tx_stream: got byte %02h with otx_en=1, required no transmission", otx_d);
          end else begin
            exp_b = exp_q.pop_front();
            if (otx_d !== exp_b) begin
              miscompares++;
              $display("FAIL tx_stream: got %02h, required %02h", otx_d, exp_b);
            end
          end
        end else begin
          low_run++;
          if (otx_d !== 8'h00) begin
            miscompares++;
            $display("FAIL idle_data: got %02h, required 00 while otx_en=0", otx_d);
          end
        end
        prev_en = otx_en;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_pkt(input int len, input int last_at, input bit rnd);
    logic [7:0] b;
    st_lens.push_back(len);
    if (len <= MAX_LEN) begin
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
    end
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : 8'(i);
      st_bytes.push_back({(i == last_at), b});
      if (len <= MAX_LEN) exp_q.push_back(b);
    end
`ifdef PACKET_TX_PAD_EN
    if (len <= MAX_LEN)
      for (int i = len; i < 60; i++) exp_q.push_back(8'h00);
`endif
    if (len <= MAX_LEN) exp_frames++;
  endtask

  task automatic clear_counts();
    tx_en_cnt = 0;
    ord_cnt   = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge iclk); #1;
      if (exp_q.size() == 0 && st_lens.size() == 0 && !obusy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge iclk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    ien     = 1'b1;
    #1;
    vectors++;
    if ({otx_en, store_bus.ord_en, obusy, oerr_len, oerr_sync} !== 5'b0 || otx_d !== 8'h00 || oframes !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: got en=%b rd=%b busy=%b el=%b es=%b d=%02h fr=%0d, required all 0",
               otx_en, store_bus.ord_en, obusy, oerr_len, oerr_sync, otx_d, oframes);
    end
    repeat (3) @(negedge iclk);
    i_rst_n = 1'b1;
    mon_off = 1'b0;
    repeat (5) @(negedge iclk);
    #1;
    vectors++;
    if (obusy !== 1'b0 || store_bus.ord_en !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b rd=%b, required 0 0", obusy, store_bus.ord_en);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    clear_counts();
    push_pkt(64, 63, 1'b0);
    wait_done(400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL single_timeout: frame did not complete in 400 cycles"); end
    vectors++;
    if (tx_en_cnt != 72) begin miscompares++; $display("FAIL single_tx_en: got %0d cycles, required 72", tx_en_cnt); end
    vectors++;
    if (ord_cnt != 64) begin miscompares++; $display("FAIL single_ord_en: got %0d cycles, required 64", ord_cnt); end
    vectors++;
    if (oframes !== 16'(exp_frames)) begin miscompares++; $display("FAIL single_frames: got %0d, required %0d", oframes, exp_frames); end
    vectors++;
    if ({oerr_len, oerr_sync} !== 2'b00) begin miscompares++; $display("FAIL single_flags: got %b%b, required 00", oerr_len, oerr_sync); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_counts();
    push_pkt(60, 59, 1'b1);
    push_pkt(60, 59, 1'b1);
    wait_done(600, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_timeout: frames did not complete in 600 cycles"); end
    vectors++;
    if (last_gap != 12) begin miscompares++; $display("FAIL b2b_gap: got %0d idle cycles, required 12", last_gap); end
    vectors++;
    if (tx_en_cnt != 136) begin miscompares++; $display("FAIL b2b_tx_en: got %0d cycles, required 136", tx_en_cnt); end
    vectors++;
    if (oframes !== 16'(exp_frames)) begin miscompares++; $display("FAIL b2b_frames: got %0d, required %0d", oframes, exp_frames); end
  endtask

  task automatic test_short_frame();
    bit ok;
    int exp_en;
`ifdef PACKET_TX_PAD_EN
    exp_en = 68;
`else
    exp_en = 18;
`endif
    clear_counts();
    push_pkt(10, 9, 1'b1);
    wait_done(300, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL short_timeout: frame did not complete in 300 cycles"); end
    vectors++;
    if (tx_en_cnt != exp_en) begin miscompares++; $display("FAIL short_tx_en: got %0d cycles, required %0d", tx_en_cnt, exp_en); end
    vectors++;
    if (ord_cnt != 10) begin miscompares++; $display("FAIL short_ord_en: got %0d cycles, required 10", ord_cnt); end
    vectors++;
    if (oframes !== 16'(exp_frames)) begin miscompares++; $display("FAIL short_frames: got %0d, required %0d", oframes, exp_frames); end
  endtask

  task automatic test_oversize();
    bit ok;
    clear_counts();
    push_pkt(1600, 1599, 1'b1);
    wait_done(2500, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL over_timeout: discard did not complete in 2500 cycles"); end
    vectors++;
    if (ord_cnt != 1600) begin miscompares++; $display("FAIL over_ord_en: got %0d cycles, required 1600", ord_cnt); end
    vectors++;
    if (tx_en_cnt != 0) begin miscompares++; $display("FAIL over_tx_en: got %0d cycles, required 0", tx_en_cnt); end
    vectors++;
    if (oerr_len !== 1'b1) begin miscompares++; $display("FAIL over_err_len: got %b, required 1", oerr_len); end
    vectors++;
    if (oerr_sync !== 1'b0) begin miscompares++; $display("FAIL over_err_sync: got %b, required 0", oerr_sync); end
    vectors++;
    if (oframes !== 16'(exp_frames)) begin miscompares++; $display("FAIL over_frames: got %0d, required %0d", oframes, exp_frames); end
  endtask

  task automatic test_sync_error();
    bit ok;
    clear_counts();
    push_pkt(64, 40, 1'b1);
    wait_done(400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL sync_timeout: frame did not complete in 400 cycles"); end
    vectors++;
    if (tx_en_cnt != 72) begin miscompares++; $display("FAIL sync_tx_en: got %0d cycles, required 72", tx_en_cnt); end
    vectors++;
    if (oerr_sync !== 1'b1) begin miscompares++; $display("FAIL sync_flag: got %b, required 1", oerr_sync); end
    vectors++;
    if (oframes !== 16'(exp_frames)) begin miscompares++; $display("FAIL sync_frames: got %0d, required %0d", oframes, exp_frames); end
  endtask

  task automatic test_ien_gate();
    bit ok;
    bit seen;
    ien = 1'b0;
    clear_counts();
    push_pkt(20, 19, 1'b1);
    repeat (40) @(negedge iclk);
    #1;
    vectors++;
    if (ord_cnt != 0 || tx_en_cnt != 0 || obusy !== 1'b0) begin
      miscompares++;
      $display("FAIL ien_hold: got rd=%0d en=%0d busy=%b, required 0 0 0", ord_cnt, tx_en_cnt, obusy);
    end
    ien  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge iclk); #1;
      if (tx_en_cnt > 0) begin seen = 1'b1; break; end
    end
    ien = 1'b0;
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL ien_start: got no otx_en within 10 cycles, required start"); end
    wait_done(300, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ien_timeout: frame did not complete in 300 cycles"); end
    vectors++;
    if (tx_en_cnt != 28 || ord_cnt != 20) begin
      miscompares++;
      $display("FAIL ien_midframe: got en=%0d rd=%0d, required 28 20", tx_en_cnt, ord_cnt);
    end
    vectors++;
    if (oframes !== 16'(exp_frames)) begin miscompares++; $display("FAIL ien_frames: got %0d, required %0d", oframes, exp_frames); end
    ien = 1'b1;
  endtask

  task automatic test_async_reset();
    bit seen;
    clear_counts();
    push_pkt(64, 63, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge iclk); #1;
      if (tx_en_cnt == 29) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL arst_reach: data byte 20 not reached in 200 cycles"); end
    vectors++;
    if (otx_d !== 8'h14 || store_bus.ord_en !== 1'b1 || obusy !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_before: got d=%02h rd=%b busy=%b, required 14 1 1", otx_d, store_bus.ord_en, obusy);
    end
    mon_off = 1'b1;
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if (otx_en !== 1'b0 || store_bus.ord_en !== 1'b0 || otx_d !== 8'h00) begin
      miscompares++;
      $display("FAIL arst_async: got en=%b rd=%b d=%02h, required 0 0 00", otx_en, store_bus.ord_en, otx_d);
    end
    st_bytes.delete();
    st_lens.delete();
    exp_q.delete();
    st_cnt     = 0;
    pend       = 1'b0;
    exp_frames = 0;
    repeat (3) @(negedge iclk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge iclk);
    #1;
    vectors++;
    if (obusy !== 1'b0 || oerr_len !== 1'b0 || oerr_sync !== 1'b0 || oframes !== 16'h0) begin
      miscompares++;
      $display("FAIL arst_after: got busy=%b el=%b es=%b fr=%0d, required 0 0 0 0", obusy, oerr_len, oerr_sync, oframes);
    end
    prev_en = 1'b0;
    mon_off = 1'b0;
  endtask

  initial begin : run
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_short_frame();
    test_oversize();
    test_sync_error();
    test_ien_gate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
